// File: rtl/delay_line_pkg.sv
// Shared helpers for the delay_line block: parameter legality checking.
package delay_line_pkg;

  function automatic bit params_legal(int width, int depth);
    return (width >= 1) && (depth >= 0);
  endfunction

endpackage

// File: rtl/delay_line.sv
// Synchronous delay line: dout reproduces din exactly DEPTH clock cycles later.
// DEPTH=0 degenerates to a combinational wire; otherwise a resettable register chain.
module delay_line
  import delay_line_pkg::*;
#(
  parameter int               WIDTH       = 1,
  parameter int               DEPTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  if (!params_legal(WIDTH, DEPTH)) begin : g_bad_params
    $error("delay_line: illegal parameters WIDTH=%0d DEPTH=%0d", WIDTH, DEPTH);
  end

  if (DEPTH == 0) begin : g_passthru
    // Clock and reset are intentionally unused in the zero-latency form.
    logic unused_clk_reset;
    assign unused_clk_reset = clk ^ reset;
    assign dout             = din;
  end else begin : g_chain
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] stage_d;
      logic [WIDTH-1:0] stage_q;

      if (gi == 0) begin : g_head
        always_comb stage_d = din;
      end else begin : g_link
        always_comb stage_d = g_stage[gi-1].stage_q;
      end

      always_ff @(posedge clk) begin
        if (reset) stage_q <= RESET_VALUE;
        else       stage_q <= stage_d;
      end
    end

    assign dout = g_stage[DEPTH-1].stage_q;
  end

endmodule

// File: tb/tb_delay_line.sv
// Bench for delay_line: four configurations driven together, checked every cycle
// against a history-based model, plus directed scenarios with literal expectations.
module tb_delay_line;

  localparam int NL = 4;
  localparam int NH = 1024;
  localparam int DEP [NL] = '{1, 4, 3, 0};
  localparam logic [7:0] RV  [NL] = '{8'h00, 8'h00, 8'hA5, 8'h00};
  localparam logic [7:0] MSK [NL] = '{8'h01, 8'hFF, 8'hFF, 8'h0F};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] din_v [NL];
  logic       rst_v [NL];

  logic       din0, dout0;
  logic [7:0] din1, dout1;
  logic [7:0] din2, dout2;
  logic [3:0] din3, dout3;

  assign din0 = din_v[0][0];
  assign din1 = din_v[1];
  assign din2 = din_v[2];
  assign din3 = din_v[3][3:0];

  delay_line u_d0 (.clk(clk), .reset(rst_v[0]), .din(din0), .dout(dout0));
  delay_line #(.WIDTH(8), .DEPTH(4)) u_d1 (.clk(clk), .reset(rst_v[1]), .din(din1), .dout(dout1));
  delay_line #(.WIDTH(8), .DEPTH(3), .RESET_VALUE(8'hA5))
    u_d2 (.clk(clk), .reset(rst_v[2]), .din(din2), .dout(dout2));
  delay_line #(.WIDTH(4), .DEPTH(0)) u_d3 (.clk(clk), .reset(rst_v[3]), .din(din3), .dout(dout3));

  // Model state: what every lane was presented with at each edge.
  logic [7:0] dh [NL][NH];
  bit         rh [NL][NH];
  int         first_rst [NL];
  int         e = 0;

  int n_tests = 0;
  int n_fail  = 0;
  bit count_pulses = 1'b0;
  int pulses = 0;

  function automatic logic [7:0] dout_of(int l);
    case (l)
      0:       return {7'd0, dout0};
      1:       return dout1;
      2:       return dout2;
      default: return {4'd0, dout3};
    endcase
  endfunction

  // Value after e edges = din from DEPTH edges ago, unless a reset landed in that window.
  function automatic bit model_expect(int l, output logic [7:0] v);
    int src;
    src = e - DEP[l];
    v   = RV[l];
    if (e == 0) return 1'b0;
    for (int k = (src < 0) ? 0 : src; k < e; k++)
      if (rh[l][k]) return 1'b1;
    if (src < 0 || first_rst[l] >= src) return 1'b0;
    v = dh[l][src] & MSK[l];
    return 1'b1;
  endfunction

  task automatic chk(input string name, input int l, input logic [7:0] got, input logic [7:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s lane%0d edge%0d: got %h, expected %h", name, l, e, got, exp);
    end
  endtask

  task automatic tick();
    if (e >= NH) begin
      $display("FAIL history_bound: edge count %0d exceeded %0d", e, NH);
      $fatal(1, "history overflow");
    end
    for (int l = 0; l < NL; l++) begin
      dh[l][e] = din_v[l];
      rh[l][e] = rst_v[l];
      if (rst_v[l] && first_rst[l] > e) first_rst[l] = e;
    end
    @(posedge clk);
    e++;
    #1;
  endtask

  // Compare process: every lane against the model on every falling edge.
  initial begin
    logic [7:0] exp_v;
    forever begin
      @(negedge clk);
      for (int l = 0; l < NL; l++) begin
        if (DEP[l] == 0) chk("model_comb", l, dout_of(l), din_v[l] & MSK[l]);
        else if (model_expect(l, exp_v)) chk("model", l, dout_of(l), exp_v);
      end
      if (count_pulses && din0 && !dout0) pulses++;
    end
  end

  initial begin
    for (int l = 0; l < NL; l++) begin
      din_v[l] = 8'h00;
      rst_v[l] = 1'b1;
      first_rst[l] = 1 << 30;
    end

    // Default config: two reset cycles, din high for three cycles, then low.
    din_v[2] = 8'h5A;
    count_pulses = 1'b1;
    tick(); chk("rst_d1", 0, dout_of(0), 8'h00); chk("rst_rv", 2, dout_of(2), 8'hA5);
    tick(); chk("rst_d1", 0, dout_of(0), 8'h00);
    for (int l = 0; l < NL; l++) rst_v[l] = 1'b0;
    din_v[0] = 8'h01;
    for (int i = 0; i < 3; i++) begin
      tick(); chk("pulse_hi", 0, dout_of(0), 8'h01);
    end
    din_v[0] = 8'h00;
    tick(); chk("pulse_lo", 0, dout_of(0), 8'h00);
    tick(); chk("pulse_lo", 0, dout_of(0), 8'h00);
    count_pulses = 1'b0;
    chk("edge_detect_count", 0, 8'(pulses), 8'd1);

    // Back-to-back ramp through the 4-deep lane.
    for (int i = 0; i < 20; i++) begin
      din_v[1] = (i < 16) ? 8'(i + 1) : 8'h00;
      tick();
      if (i >= 3 && i < 19) chk("ramp", 1, dout_of(1), 8'(i - 2));
    end

    // Custom reset value, then release onto a constant input.
    rst_v[2] = 1'b1; din_v[2] = 8'hFF;
    tick(); chk("rv_load", 2, dout_of(2), 8'hA5);
    rst_v[2] = 1'b0; din_v[2] = 8'h3C;
    tick(); chk("rv_hold1", 2, dout_of(2), 8'hA5);
    tick(); chk("rv_hold2", 2, dout_of(2), 8'hA5);
    tick(); chk("rv_release", 2, dout_of(2), 8'h3C);

    // Mid-stream reset discards everything in flight.
    for (int i = 0; i < 4; i++) begin
      din_v[1] = 8'h11 + 8'(i);
      tick();
    end
    rst_v[1] = 1'b1; din_v[1] = 8'h15;
    tick(); chk("flush_rst", 1, dout_of(1), 8'h00);
    rst_v[1] = 1'b0; din_v[1] = 8'h00;
    for (int i = 0; i < 6; i++) begin
      tick(); chk("flush_after", 1, dout_of(1), 8'h00);
    end

    // Zero-depth lane follows din within the cycle, reset or not.
    for (int i = 0; i < 6; i++) begin
      din_v[3] = (i % 2 == 0) ? 8'h0F : 8'h00;
      rst_v[3] = (i >= 2 && i < 4);
      #1 chk("comb_now", 3, dout_of(3), din_v[3]);
      tick();
    end
    rst_v[3] = 1'b0;

    // Single-bit toggle: dout alternates one cycle behind din.
    for (int i = 0; i < 8; i++) begin
      din_v[0] = 8'(i % 2);
      tick(); chk("toggle", 0, dout_of(0), 8'(i % 2));
    end

    // Random traffic with sporadic per-lane resets.
    for (int i = 0; i < 400; i++) begin
      for (int l = 0; l < NL; l++) begin
        din_v[l] = 8'($urandom_range(0, 255)) & MSK[l];
        rst_v[l] = ($urandom_range(0, 15) == 0);
      end
      tick();
    end
    for (int l = 0; l < NL; l++) rst_v[l] = 1'b0;
    tick(); tick();
    @(negedge clk);
    #1;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
